// File: rtl/conv1d_par_stream.sv
// Streaming 1-D convolution: filter and input vector arrive over ready/valid and are
// convolved on P parallel MAC lanes. Each output is rescaled, saturated and optionally ReLU-clamped.
module conv1d_par_stream #(
  parameter int WIDTH = 16,
  parameter int LENX  = 32,
  parameter int LENF  = 9,
  parameter int P     = 3,
  parameter int FRAC  = 0,
  parameter int RELU  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in_f,
  input  logic             s_valid_f,
  output logic             s_ready_f,
  input  logic [WIDTH-1:0] s_data_in_x,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic [WIDTH-1:0] m_data_out_y,
  output logic             m_valid_y,
  input  logic             m_ready_y
);

  // state   | meaning
  // S_LOADF | accepting LENF filter coefficients, f[0] first
  // S_LOADX | accepting LENX input samples, x[0] first
  // S_COMP  | j<LENF: one tap per cycle on every lane; j==LENF: latch lane results
  // S_OUT   | presenting the nv valid lane results of group g

  localparam int SIZE = LENX - LENF + 1;
  localparam int NG   = (SIZE + P - 1) / P;
  localparam int ACCW = 2*WIDTH + $clog2(LENF) + 1;
  localparam int PW   = 2*WIDTH;
  localparam int FCW  = $clog2(LENF + 1);
  localparam int XCW  = $clog2(LENX + 1);
  localparam int JW   = $clog2(LENF + 1);
  localparam int GW   = $clog2(NG + 1);
  localparam int BW   = $clog2(LENX + 1);
  localparam int OW   = (P > 1) ? $clog2(P) : 1;
  localparam int FAW  = (LENF > 1) ? $clog2(LENF) : 1;
  localparam int XAW  = (LENX > 1) ? $clog2(LENX) : 1;

  localparam logic signed [ACCW-1:0] Y_MAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] Y_MIN = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] S_LOADF = 2'd0;
  localparam logic [1:0] S_LOADX = 2'd1;
  localparam logic [1:0] S_COMP  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]     state, state_nxt;
  logic [FCW-1:0] cnt_f;
  logic [XCW-1:0] cnt_x;
  logic [JW-1:0]  j, j_tap;
  logic [GW-1:0]  g;
  logic [BW-1:0]  base;
  logic [OW-1:0]  o_idx;

  logic signed [WIDTH-1:0] f_mem [LENF];
  logic signed [WIDTH-1:0] x_mem [LENX];
  logic signed [ACCW-1:0]  acc   [P];
  logic [WIDTH-1:0]        obuf  [P];
  logic signed [PW-1:0]    lane_prod [P];
  logic signed [WIDTH-1:0] f_coef;

  logic fire_f, fire_x, fire_y;
  logic f_last, x_last, tap_done, last_lane, last_group;
  int   rem;

  assign fire_f     = s_valid_f & s_ready_f;
  assign fire_x     = s_valid_x & s_ready_x;
  assign fire_y     = m_valid_y & m_ready_y;
  assign f_last     = (cnt_f == FCW'(LENF-1));
  assign x_last     = (cnt_x == XCW'(LENX-1));
  assign tap_done   = (j == JW'(LENF));
  assign last_group = (g == GW'(NG-1));
  assign j_tap      = tap_done ? '0 : j;
  assign f_coef     = f_mem[FAW'(j_tap)];
  assign m_data_out_y = obuf[o_idx];

  // Lanes past the end of the output range stay idle so they never index beyond x.
  always_comb begin
    for (int k = 0; k < P; k++) begin
      lane_prod[k] = '0;
      if (int'(base) + k < SIZE)
        lane_prod[k] = PW'(x_mem[XAW'(int'(base) + k + int'(j_tap))]) * PW'(f_coef);
    end
  end

  always_comb begin
    rem       = SIZE - int'(base);
    last_lane = (int'(o_idx) == ((rem < P) ? rem : P) - 1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOADF: if (fire_f && f_last) state_nxt = S_LOADX;
      S_LOADX: if (fire_x && x_last) state_nxt = S_COMP;
      S_COMP:  if (tap_done) state_nxt = S_OUT;
      S_OUT: begin
        if (fire_y && last_lane) begin
          if (!last_group)    state_nxt = S_COMP;
          else if (s_valid_f) state_nxt = S_LOADF;
          else                state_nxt = S_LOADX;
        end
      end
      default: state_nxt = S_LOADF;
    endcase
  end

  function automatic logic [WIDTH-1:0] post_proc(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] r;
    r = a >>> FRAC;
    if (r > Y_MAX)      r = Y_MAX;
    else if (r < Y_MIN) r = Y_MIN;
    if (RELU != 0 && r[ACCW-1]) r = '0;
    return r[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (fire_f) f_mem[FAW'(cnt_f)] <= s_data_in_f;
    if (fire_x) x_mem[XAW'(cnt_x)] <= s_data_in_x;
  end

  // j==0 loads the first product, which clears whatever the previous group left behind.
  always_ff @(posedge clk) begin
    if (state == S_COMP && !tap_done) begin
      for (int k = 0; k < P; k++)
        acc[k] <= (j == '0) ? ACCW'(lane_prod[k]) : acc[k] + ACCW'(lane_prod[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_LOADF;
      cnt_f     <= '0;
      cnt_x     <= '0;
      j         <= '0;
      g         <= '0;
      base      <= '0;
      o_idx     <= '0;
      s_ready_f <= 1'b0;
      s_ready_x <= 1'b0;
      m_valid_y <= 1'b0;
      for (int k = 0; k < P; k++) obuf[k] <= '0;
    end else begin
      state     <= state_nxt;
      s_ready_f <= (state_nxt == S_LOADF);
      s_ready_x <= (state_nxt == S_LOADX);
      m_valid_y <= (state_nxt == S_OUT);
      case (state)
        S_LOADF: if (fire_f) cnt_f <= f_last ? '0 : cnt_f + FCW'(1);
        S_LOADX: if (fire_x) cnt_x <= x_last ? '0 : cnt_x + XCW'(1);
        S_COMP: begin
          if (tap_done) begin
            j <= '0;
            for (int k = 0; k < P; k++) obuf[k] <= post_proc(acc[k]);
          end else begin
            j <= j + JW'(1);
          end
        end
        S_OUT: begin
          if (fire_y) begin
            if (last_lane) begin
              o_idx <= '0;
              if (last_group) begin
                g    <= '0;
                base <= '0;
              end else begin
                g    <= g + GW'(1);
                base <= base + BW'(P);
              end
            end else begin
              o_idx <= o_idx + OW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
